// File: rtl/bsg_dff_rr_share_ctrl_pkg.sv
// Shared sizing helpers for round-robin shared-register controllers.
// Bank-level wrappers use these so tag widths and reset pointers agree.
package bsg_dff_share_pkg;

  function automatic int tag_width(input int els);
    return (els > 2) ? $clog2(els) : 1;
  endfunction

  function automatic int rst_last(input int els);
    return els - 1;
  endfunction

endpackage

// File: rtl/bsg_dff_rr_share_ctrl_if.sv
// Requester/consumer handshake bundle of the shared-register controller.
// Signal names are from the controller's point of view.
interface bsg_dff_rr_share_ctrl_if
  import bsg_dff_share_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 3,
  parameter int tag_w_p = tag_width(els_p)
) ();

  logic [els_p-1:0]         v_i;
  logic [els_p*width_p-1:0] data_i;
  logic [els_p-1:0]         yumi_o;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic [tag_w_p-1:0]       tag_o;
  logic                     yumi_i;

  modport slave (
    input  v_i, data_i, yumi_i,
    output yumi_o, v_o, data_o, tag_o
  );

  modport master (
    output v_i, data_i, yumi_i,
    input  yumi_o, v_o, data_o, tag_o
  );

endinterface

// File: rtl/bsg_dff_rr_share_ctrl_arb.sv
// Combinational round-robin pick: first valid requester after last_i,
// searched in rotated order and priority encoded.
module bsg_rr_share_arb #(
  parameter int els_p   = 4,
  parameter int tag_w_p = 2
) (
  input  logic [els_p-1:0]   v_i,
  input  logic [tag_w_p-1:0] last_i,
  output logic [els_p-1:0]   grant_oh_o,
  output logic [tag_w_p-1:0] grant_o,
  output logic               v_any_o
);

  int w_idx;
  int w_sel;

  // Walk from the farthest slot back to the nearest; the nearest hit wins.
  always_comb begin
    w_sel      = 0;
    w_idx      = 0;
    grant_oh_o = '0;
    for (int j = els_p - 1; j >= 0; j--) begin
      w_idx = int'(last_i) + 1 + j;
      if (w_idx >= els_p) w_idx = w_idx - els_p;
      if (v_i[w_idx]) w_sel = w_idx;
    end
    v_any_o = |v_i;
    grant_o = tag_w_p'(w_sel);
    if (v_any_o) grant_oh_o[w_sel] = 1'b1;
  end

endmodule

// File: rtl/bsg_dff_rr_share_ctrl.sv
// Round-robin controller that lets several requesters take turns
// loading one shared registered bus of data plus source tag.
module bsg_dff_rr_share_ctrl
  import bsg_dff_share_pkg::*;
#(
  parameter int els_p    = 4,
  parameter int width_p  = 3,
  parameter int harden_p = 1
) (
  input logic                     clk_i,
  input logic                     reset_i,
  bsg_dff_rr_share_ctrl_if.slave  io
);

  localparam int tag_w_lp = tag_width(els_p);
  localparam logic [tag_w_lp-1:0] rst_last_lp = tag_w_lp'(rst_last(els_p));

  logic                r_full;
  logic [tag_w_lp-1:0] r_last;
  logic [tag_w_lp-1:0] r_tag;
  logic [width_p-1:0]  r_data;

  logic [els_p-1:0]    w_oh;
  logic [tag_w_lp-1:0] w_g;
  logic                w_v_any;
  logic                w_load;
  logic                w_deq;
  logic [width_p-1:0]  w_sel;
  logic [width_p-1:0]  w_data_n;

  bsg_rr_share_arb #(
    .els_p   (els_p),
    .tag_w_p (tag_w_lp)
  ) arb (
    .v_i        (io.v_i),
    .last_i     (r_last),
    .grant_oh_o (w_oh),
    .grant_o    (w_g),
    .v_any_o    (w_v_any)
  );

  // Load when someone asks and the slot is empty or draining now.
  always_comb begin
    w_load   = ~reset_i & w_v_any & (~r_full | io.yumi_i);
    w_deq    = io.yumi_i & r_full;
    w_sel    = io.data_i[int'(w_g)*width_p +: width_p];
    w_data_n = reset_i ? '0 : (w_load ? w_sel : r_data);
  end

  assign io.yumi_o = w_load ? w_oh : '0;
  assign io.v_o    = r_full;
  assign io.data_o = r_data;
  assign io.tag_o  = r_tag;

  // Control state: occupancy, source tag and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_full <= 1'b0;
      r_last <= rst_last_lp;
      r_tag  <= '0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_last <= w_g;
      r_tag  <= w_g;
    end else if (w_deq) begin
      r_full <= 1'b0;
    end
  end

  if (harden_p != 0) begin : g_hard
    // Plain D flops fed by the next-value mux, mapping onto hard cells.
    always_ff @(posedge clk_i) begin
      r_data <= w_data_n;
    end
  end else begin : g_soft
    // Enable-style payload register.
    always_ff @(posedge clk_i) begin
      if (reset_i) r_data <= '0;
      else if (w_load) r_data <= w_sel;
    end
  end

endmodule

// File: tb/tb_bsg_dff_rr_share_ctrl.sv
// Directed vector table plus scoreboarded random soak for
// the round-robin shared-register controller.
module tb_bsg_dff_rr_share_ctrl;

  localparam int ELS = 4;
  localparam int W   = 3;
  localparam int TW  = 2;
  localparam int NV  = 26;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [11:0] d;
    logic        yi;
    logic [3:0]  ey;
    logic        ev;
    logic [2:0]  ed;
    logic [1:0]  et;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bsg_dff_rr_share_ctrl_if #(.els_p(ELS), .width_p(W)) bus ();

  bsg_dff_rr_share_ctrl #(
    .els_p    (ELS),
    .width_p  (W),
    .harden_p (1)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .io      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.yumi_i && !bus.v_o) begin
      errors++;
      $display("FAIL yumi_i_illegal: got yumi_i=1 v_o=0, required v_o=1");
    end
  end

  vec_t tv[NV];

  function automatic vec_t mk(input logic r, input logic [3:0] v,
                              input logic [11:0] d, input logic yi,
                              input logic [3:0] ey, input logic ev,
                              input logic [2:0] ed, input logic [1:0] et);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.yi = yi;
    t.ey = ey; t.ev = ev; t.ed = ed; t.et = et;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int last);
    for (int i = 1; i <= ELS; i++) begin
      int idx;
      idx = (last + i) % ELS;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  logic [11:0] DA;
  logic [11:0] DB;

  // soak model state
  logic        m_full;
  int          m_last;
  logic [2:0]  m_data;
  logic [1:0]  m_tag;
  logic [3:0]  held;
  logic [11:0] hdat;
  int          waitc[ELS];
  logic [4:0]  sbq[$];

  initial begin
    checks = 0;
    errors = 0;
    DA = {3'd4, 3'd3, 3'd2, 3'd1};
    DB = {3'd4, 3'd5, 3'd2, 3'd1};

    tv[0]  = mk(1, 4'b1111, DA, 0, 4'b0000, 0, 0, 0);
    tv[1]  = mk(0, 4'b1111, DA, 0, 4'b0001, 0, 0, 0);
    tv[2]  = mk(0, 4'b1111, DA, 1, 4'b0010, 1, 1, 0);
    tv[3]  = mk(0, 4'b1111, DA, 1, 4'b0100, 1, 2, 1);
    tv[4]  = mk(0, 4'b1111, DA, 1, 4'b1000, 1, 3, 2);
    tv[5]  = mk(0, 4'b1111, DA, 1, 4'b0001, 1, 4, 3);
    tv[6]  = mk(0, 4'b0000, DA, 1, 4'b0000, 1, 1, 0);
    tv[7]  = mk(0, 4'b0000, DA, 0, 4'b0000, 0, 1, 0);
    tv[8]  = mk(0, 4'b0100, DB, 0, 4'b0100, 0, 1, 0);
    for (int i = 9; i <= 13; i++)
      tv[i] = mk(0, 4'b0011, DB, 0, 4'b0000, 1, 5, 2);
    tv[14] = mk(0, 4'b0011, DB, 1, 4'b0001, 1, 5, 2);
    tv[15] = mk(0, 4'b0011, DB, 1, 4'b0010, 1, 1, 0);
    tv[16] = mk(1, 4'b0011, DB, 0, 4'b0000, 1, 2, 1);
    tv[17] = mk(0, 4'b0011, DB, 0, 4'b0001, 0, 0, 0);
    tv[18] = mk(0, 4'b1000, DB, 1, 4'b1000, 1, 1, 0);
    tv[19] = mk(0, 4'b0100, DB, 1, 4'b0100, 1, 4, 3);
    tv[20] = mk(0, 4'b0000, DB, 1, 4'b0000, 1, 5, 2);
    tv[21] = mk(0, 4'b0000, DB, 0, 4'b0000, 0, 5, 2);
    tv[22] = mk(0, 4'b0010, DB, 0, 4'b0010, 0, 5, 2);
    tv[23] = mk(0, 4'b0100, DB, 0, 4'b0000, 1, 2, 1);
    tv[24] = mk(0, 4'b0001, DB, 1, 4'b0001, 1, 2, 1);
    tv[25] = mk(0, 4'b0000, DB, 1, 4'b0000, 1, 1, 0);

    rst        = 1'b1;
    bus.v_i    = 4'b1111;
    bus.data_i = DA;
    bus.yumi_i = 1'b0;
    @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      rst        = tv[k].rst;
      bus.v_i    = tv[k].v;
      bus.data_i = tv[k].d;
      bus.yumi_i = tv[k].yi;
      #1;
      chk($sformatf("v%0d_yumi_o", k), 32'(bus.yumi_o), 32'(tv[k].ey));
      chk($sformatf("v%0d_v_o", k), 32'(bus.v_o), 32'(tv[k].ev));
      chk($sformatf("v%0d_data_o", k), 32'(bus.data_o), 32'(tv[k].ed));
      chk($sformatf("v%0d_tag_o", k), 32'(bus.tag_o), 32'(tv[k].et));
    end

    // random soak against a reference model and scoreboard
    @(negedge clk);
    rst = 1'b1;
    bus.v_i = '0;
    bus.yumi_i = 1'b0;
    @(posedge clk);
    m_full = 1'b0;
    m_last = ELS - 1;
    m_data = '0;
    m_tag  = '0;
    held   = '0;
    hdat   = '0;
    for (int r = 0; r < ELS; r++) waitc[r] = 0;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      int         g;
      logic       ld;
      logic [3:0] v;
      logic [3:0] eoh;
      logic [11:0] d;
      @(negedge clk);
      rst = 1'b0;
      d = 12'($urandom);
      v = 4'($urandom);
      for (int r = 0; r < ELS; r++)
        if (held[r]) begin
          v[r] = 1'b1;
          d[r*W +: W] = hdat[r*W +: W];
        end
      bus.v_i    = v;
      bus.data_i = d;
      bus.yumi_i = m_full & ($urandom_range(0, 3) != 0);
      #1;
      g   = pick(v, m_last);
      ld  = (g >= 0) && (!m_full || bus.yumi_i);
      eoh = '0;
      if (ld) eoh[g] = 1'b1;
      chk("soak_yumi_o", 32'(bus.yumi_o), 32'(eoh));
      chk("soak_v_o", 32'(bus.v_o), 32'(m_full));
      if (m_full) begin
        chk("soak_data_o", 32'(bus.data_o), 32'(m_data));
        chk("soak_tag_o", 32'(bus.tag_o), 32'(m_tag));
      end
      if (bus.yumi_i && m_full) begin
        if (sbq.size() == 0) begin
          chk("soak_sb_empty", 32'(sbq.size()), 32'd1);
        end else begin
          logic [4:0] it;
          it = sbq.pop_front();
          chk("soak_sb_item", 32'({bus.tag_o, bus.data_o}), 32'(it));
        end
      end
      if (ld) begin
        for (int r = 0; r < ELS; r++) begin
          if (r == g) waitc[r] = 0;
          else if (v[r]) begin
            waitc[r]++;
            chk($sformatf("soak_fair_r%0d", r),
                32'(waitc[r] > ELS - 1), 32'd0);
          end
        end
        m_data = d[g*W +: W];
        m_tag  = 2'(g);
        m_last = g;
        m_full = 1'b1;
        sbq.push_back({m_tag, m_data});
      end else if (bus.yumi_i && m_full) begin
        m_full = 1'b0;
      end
      for (int r = 0; r < ELS; r++) begin
        held[r] = v[r] && !(ld && r == g);
        if (!held[r]) waitc[r] = 0;
      end
      hdat = d;
    end

    chk("soak_sb_left", 32'(sbq.size()), 32'(m_full));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_dff_rr_share_ctrl.md
# bsg_dff_rr_share_ctrl

Round-robin controller that shares one hardened output register (a bank of `width_p` flops) among `els_p` requesters. Each cycle it picks at most one valid requester, loads that requester's data and index into the shared register, and holds it until the downstream consumer takes it. It sits in front of shared narrow control registers in the bp_quad datapath, where several sources must take turns driving one registered bus.

## Interface
- `els_p`, 4, number of requesters; ≥2
- `width_p`, 3, payload width of the shared register
- `harden_p`, 1, passed to the register sub-instance; no functional effect
- `clk_i`  in  1  sole clock; all state updates on posedge
- `reset_i`  in  1  synchronous, active-high reset
- `v_i`  in  els_p  per-requester valid
- `data_i`  in  els_p*width_p  requester r payload at bits [r*width_p +: width_p]
- `yumi_o`  out  els_p  one-hot-or-zero; requester r's data is taken this cycle
- `v_o`  out  1  shared register holds valid data
- `data_o`  out  width_p  shared register payload
- `tag_o`  out  max(1,$clog2(els_p))  index of the requester that supplied `data_o`
- `yumi_i`  in  1  consumer takes `data_o` this cycle; legal only when `v_o`=1

## Operation
- Handshakes are valid-then-yumi on both sides. Requesters hold `v_i[r]` and `data_i` stable until `yumi_o[r]`. The consumer raises `yumi_i` only while `v_o`=1.
- Register state is {full, data, tag}.
- `load = v_any & (~full | yumi_i)`, where `v_any = |v_i`.
- Arbitration is combinational from the current `v_i` and the round-robin pointer `last_r`.
  - Search order: `last_r+1, last_r+2, …`, wrapping modulo `els_p`.
  - The first valid requester is the winner `g`.
- `yumi_o[g] = load`. All other bits are 0.
- On load:
  - data ← `data_i[g]`, tag ← `g`, full ← 1, `last_r` ← `g`.
  - `last_r` advances only on load; it is unchanged while requests are blocked.
- With `yumi_i` and no load: full ← 0. data and tag hold their values, but they are don't-care while `v_o`=0.
- `v_o = full`. `data_o` and `tag_o` come straight from the register.
- Wrap-around: when `last_r = els_p-1`, the search starts at 0.
- Simultaneous `yumi_i` and load: the register is drained and refilled in the same cycle, `v_o` stays 1, and throughput is one transfer per cycle.
- Full with no `yumi_i`: `yumi_o` = 0 and all requesters stall. The grant is re-evaluated every cycle, so `g` may change if `v_i` changes (for example, a higher-priority requester arrives).
- `yumi_i` while `v_o`=0 is illegal. The bench asserts on it. The RTL treats it as no-op.

## Timing
- Reset values, applied in the cycle `reset_i` is sampled high:
  - full=0, so `v_o`=0.
  - `last_r = els_p-1`, so requester 0 has first priority.
  - data and tag are reset to 0, so `data_o`=0 and `tag_o`=0.
  - `yumi_o`=0 for as long as `reset_i`=1, regardless of `v_i`.
- Reset mid-operation: any held entry is discarded without a `yumi_i`. Requesters that were not granted keep their requests pending.
- Latency: `v_i[r]` seen with the register empty gives `yumi_o[r]` in the same cycle and `v_o`=1 on the next cycle.
- `yumi_o` depends combinationally on `v_i`, `yumi_i` and state. There is no combinational path from `data_i` to any output.
- Fairness: a continuously asserted requester is granted within `els_p` loads.

## Structure
- Shared package `bsg_dff_share_pkg`: the tag width function `max(1,$clog2(els_p))` and the reset pointer constant `els_p-1`, so bank-level wrappers compute tag widths identically.
- Sub-module `bsg_rr_share_arb`:
  - inputs: `v_i`, `last_i`; outputs: one-hot grant, encoded grant, `v_any`.
  - purely combinational, implemented as a rotate and priority-encode.
- The top level holds the pointer, the full flag, and the data+tag register. The data bits are written so the flow maps onto hardened flops when `harden_p`=1.

## Test plan
- Reset:
  - stimulus: `reset_i`=1 for 2 cycles with `v_i`=4'b1111.
  - response: `yumi_o`=0, `v_o`=0, `data_o`=0, `tag_o`=0. In the first cycle after reset, requester 0 is granted.
- Round-robin rotation:
  - stimulus: all four requesters valid with data r+1, `yumi_i`=1 whenever `v_o`=1.
  - response: grants in order 0,1,2,3,0. `data_o` reads 1,2,3,4,1 on consecutive cycles, back-to-back with `v_o` held at 1.
- Backpressure:
  - stimulus: requester 2 loads 3'b101, then `yumi_i`=0 for 5 cycles while `v_i`=4'b0011.
  - response: `v_o`=1, `data_o`=5, `tag_o`=2 held for all 5 cycles, with `yumi_o`=0 throughout. After `yumi_i`, requester 0 is granted in the same cycle.
- Wrap-around and skip:
  - stimulus: `last_r`=3, then `v_i`=4'b0100.
  - response: requester 2 is granted (0 and 1 are skipped) and `last_r` becomes 2.
- Reset mid-operation:
  - stimulus: register full with tag 1, `reset_i` pulsed for 1 cycle.
  - response: `v_o`=0 on the next cycle, the entry is dropped, and the pointer returns so requester 0 has priority.
- Random soak:
  - stimulus: random `v_i` and `yumi_i`, 10k cycles.
  - response, checked by scoreboard against a reference model:
    - every accepted item appears exactly once;
    - the tag matches its source;
    - no requester waits more than `els_p` loads while valid.
